load_store_unit: RTL

- Sits between the execute stage and the word-wide data memory (sync write, combinational read, read data forced to 0 while write enabled).
- Converts byte/halfword/word load/store requests on byte addresses into word accesses.
- Handles lane extraction, sign/zero extension, read-modify-write for sub-word stores, and misalignment detection.
- Single outstanding request; req/resp handshake; the pipeline stalls on ~req_ready.

---
 rtl/load_store_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores onto a word-wide memory.
// Optional: define LSU_RANGE_CHECK_EN to fault word indices >= MEM_DEPTH.
module load_store_unit #(
  parameter int WIDTH     = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_misalign,
  output logic             resp_fault,
  output logic [WIDTH-1:0] mem_address,
  output logic             mem_write_read,
  output logic [WIDTH-1:0] mem_write_data,
  input  logic [WIDTH-1:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RMW_RD, WRITE, RESP
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wr_q;
  logic [WIDTH-1:0] rdata_q;
  logic             mis_q, flt_q;

  logic             accept;
  logic             misalign;
  logic             idx_oor;
  logic             range_err;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [WIDTH-1:0] ext;
  logic [WIDTH-1:0] merged;

  assign accept  = req_valid && (state_q == IDLE);
  assign idx_oor = req_addr[WIDTH-1:2] >= (WIDTH-2)'(MEM_DEPTH);

`ifdef LSU_RANGE_CHECK_EN
  assign range_err = idx_oor;
`else
  logic unused_idx_oor;
  assign unused_idx_oor = idx_oor;
  assign range_err      = 1'b0;
`endif

  // Alignment and size legality of the incoming request
  always_comb begin
    misalign = 1'b0;
    unique case (1'b1)
      req_size == 2'b11: misalign = 1'b1;
      req_size == 2'b01: misalign = req_addr[0];
      req_size == 2'b10: misalign = |req_addr[1:0];
      default:           misalign = 1'b0;
    endcase
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores
  always_comb begin
    lane_b = mem_read_data[8*addr_q[1:0] +: 8];
    lane_h = mem_read_data[16*addr_q[1] +: 16];
    unique case (size_q)
      2'b00:   ext = {{(WIDTH-8){~uns_q & lane_b[7]}}, lane_b};
      2'b01:   ext = {{(WIDTH-16){~uns_q & lane_h[15]}}, lane_h};
      default: ext = mem_read_data;
    endcase
    merged = mem_read_data;
    if (size_q == 2'b00)
      merged[8*addr_q[1:0] +: 8] = wr_q[7:0];
    else
      merged[16*addr_q[1] +: 16] = wr_q[15:0];
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misalign || range_err)  state_d = RESP;
          else if (!req_we)           state_d = LOAD;
          else if (req_size == 2'b10) state_d = WRITE;
          else                        state_d = RMW_RD;
        end
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, load result and store word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wr_q    <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else if (accept) begin
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wr_q    <= req_wdata;
      rdata_q <= '0;
      mis_q   <= misalign;
      flt_q   <= range_err & ~misalign;
    end else if (state_q == LOAD) begin
      rdata_q <= ext;
    end else if (state_q == RMW_RD) begin
      wr_q    <= merged;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = (state_q == RESP);
  assign mem_write_read = (state_q == WRITE);
  assign mem_write_data = wr_q;
  assign mem_address    = {2'b00, addr_q[WIDTH-1:2]};
  assign resp_rdata     = rdata_q;
  assign resp_misalign  = mis_q;
  assign resp_fault     = flt_q;

endmodule
